// File: rtl/ase_pkg.sv
// Shared ASE definitions: CCIP config-header field widths and the MMIO read
// tracker entry record with its default sizing.
package ase_pkg;

  localparam int CCIP_CFGHDR_TID_WIDTH   = 9;
  localparam int CCIP_CFGHDR_INDEX_WIDTH = 16;

  localparam int MMIO_RDTRACK_NUM_ENTRIES = 32;
  localparam int MMIO_RDTRACK_TIMEOUT     = 512;
  localparam int MMIO_RDTRACK_TIMER_WIDTH = $clog2(MMIO_RDTRACK_TIMEOUT + 1);

  // The timer field is sized for the default timeout, so any smaller
  // TIMEOUT_CYCLES fits in the same record.
  typedef struct packed {
    logic                                active;
    logic                                expired;
    logic [CCIP_CFGHDR_TID_WIDTH-1:0]    tid;
    logic [CCIP_CFGHDR_INDEX_WIDTH-1:0]  index;
    logic [MMIO_RDTRACK_TIMER_WIDTH-1:0] timer;
  } mmio_rdtrack_entry_t;

endpackage

// File: rtl/ase_prio_enc.sv
// Lowest-set-bit priority encoder: reports the index of the lowest asserted
// bit of i_vec and whether any bit was set.
module ase_prio_enc #(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_vec,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);

  localparam int IW = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ase_mmio_rdtrack.sv
// Outstanding MMIO read tracker: allocates entries for issued reads, matches
// AFU responses by tid, times out unanswered reads and flags protocol errors.
module ase_mmio_rdtrack
  import ase_pkg::*;
#(
  parameter int NUM_ENTRIES    = MMIO_RDTRACK_NUM_ENTRIES,
  parameter int TID_WIDTH      = CCIP_CFGHDR_TID_WIDTH,
  parameter int INDEX_WIDTH    = CCIP_CFGHDR_INDEX_WIDTH,
  parameter int TIMEOUT_CYCLES = MMIO_RDTRACK_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic [TID_WIDTH-1:0]             req_tid,
  input  logic [INDEX_WIDTH-1:0]           req_index,
  output logic                             req_ready,
  input  logic                             rsp_valid,
  input  logic [TID_WIDTH-1:0]             rsp_tid,
  output logic                             rsp_ok,
  output logic                             rsp_unexpected,
  output logic [INDEX_WIDTH-1:0]           rsp_index,
  output logic                             dup_err,
  output logic                             timeout_valid,
  output logic [TID_WIDTH-1:0]             timeout_tid,
  output logic [INDEX_WIDTH-1:0]           timeout_index,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] outstanding_cnt,
  output logic                             err_sticky
);

  localparam int CW  = $clog2(NUM_ENTRIES + 1);
  localparam int IW  = $clog2(NUM_ENTRIES);
  localparam int TW  = MMIO_RDTRACK_TIMER_WIDTH;
  localparam int ETW = CCIP_CFGHDR_TID_WIDTH;
  localparam int EIW = CCIP_CFGHDR_INDEX_WIDTH;
  localparam logic [TW-1:0] EXPIRE_AT = TW'(TIMEOUT_CYCLES - 1);

  mmio_rdtrack_entry_t r_ent [NUM_ENTRIES];

  logic [CW-1:0]          r_cnt;
  logic                   r_rsp_ok, r_rsp_unexp, r_dup, r_tout_valid, r_err;
  logic [INDEX_WIDTH-1:0] r_rsp_index, r_tout_index;
  logic [TID_WIDTH-1:0]   r_tout_tid;

  logic [NUM_ENTRIES-1:0] w_live, w_free, w_expired, w_hit, w_req_match;
  logic [EIW-1:0]         w_hit_index;
  logic [IW-1:0]          w_free_idx, w_exp_idx;
  logic                   w_free_found, w_exp_found;
  logic                   w_hit_any, w_rsp_miss, w_eligible, w_dup, w_accept;

  // All matching looks at the state as it stood at the start of the cycle.
  always_comb begin
    w_live      = '0;
    w_free      = '0;
    w_expired   = '0;
    w_hit       = '0;
    w_req_match = '0;
    w_hit_index = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_live[i]      = r_ent[i].active & ~r_ent[i].expired;
      w_free[i]      = ~r_ent[i].active;
      w_expired[i]   = r_ent[i].active & r_ent[i].expired;
      w_hit[i]       = rsp_valid & w_live[i] & (r_ent[i].tid == ETW'(rsp_tid));
      w_req_match[i] = w_live[i] & (r_ent[i].tid == ETW'(req_tid));
      if (w_hit[i]) begin
        w_hit_index = w_hit_index | r_ent[i].index;
      end
    end
  end

  ase_prio_enc #(.N(NUM_ENTRIES)) u_free_enc (
    .i_vec   (w_free),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  ase_prio_enc #(.N(NUM_ENTRIES)) u_exp_enc (
    .i_vec   (w_expired),
    .o_idx   (w_exp_idx),
    .o_found (w_exp_found)
  );

  assign w_hit_any  = |w_hit;
  assign w_rsp_miss = rsp_valid & ~w_hit_any;
  assign req_ready  = (r_cnt < CW'(NUM_ENTRIES));
  assign w_eligible = req_valid & req_ready;
  // A live tid that the same-cycle response is retiring is free to be reused.
  assign w_dup      = w_eligible & (|w_req_match) & ~(rsp_valid & (rsp_tid == req_tid));
  assign w_accept   = w_eligible & ~w_dup & w_free_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_ent[i] <= '0;
      end
      r_cnt        <= '0;
      r_rsp_ok     <= 1'b0;
      r_rsp_unexp  <= 1'b0;
      r_rsp_index  <= '0;
      r_dup        <= 1'b0;
      r_tout_valid <= 1'b0;
      r_tout_tid   <= '0;
      r_tout_index <= '0;
      r_err        <= 1'b0;
    end else begin
      // Allocation targets free slots, hits live ones and reports expired
      // ones, so at most one of these branches applies to any entry.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_accept && (w_free_idx == IW'(i))) begin
          r_ent[i].active  <= 1'b1;
          r_ent[i].expired <= 1'b0;
          r_ent[i].tid     <= ETW'(req_tid);
          r_ent[i].index   <= EIW'(req_index);
          r_ent[i].timer   <= '0;
        end else if (w_hit[i] || (w_exp_found && (w_exp_idx == IW'(i)))) begin
          r_ent[i] <= '0;
        end else if (w_live[i]) begin
          r_ent[i].timer   <= r_ent[i].timer + TW'(1);
          r_ent[i].expired <= ((r_ent[i].timer + TW'(1)) == EXPIRE_AT);
        end
      end
      r_cnt        <= r_cnt + CW'(w_accept) - CW'(w_hit_any) - CW'(w_exp_found);
      r_rsp_ok     <= w_hit_any;
      r_rsp_unexp  <= w_rsp_miss;
      r_rsp_index  <= INDEX_WIDTH'(w_hit_index);
      r_dup        <= w_dup;
      r_tout_valid <= w_exp_found;
      r_tout_tid   <= w_exp_found ? TID_WIDTH'(r_ent[w_exp_idx].tid) : '0;
      r_tout_index <= w_exp_found ? INDEX_WIDTH'(r_ent[w_exp_idx].index) : '0;
      r_err        <= r_err | w_dup | w_rsp_miss | w_exp_found;
    end
  end

  assign outstanding_cnt = r_cnt;
  assign rsp_ok          = r_rsp_ok;
  assign rsp_unexpected  = r_rsp_unexp;
  assign rsp_index       = r_rsp_index;
  assign dup_err         = r_dup;
  assign timeout_valid   = r_tout_valid;
  assign timeout_tid     = r_tout_tid;
  assign timeout_index   = r_tout_index;
  assign err_sticky      = r_err;

endmodule
